// File: rtl/rf_wb_queue_if.sv
// rf_wb_queue_if: producer, lookup and register-file write-port signals of the write-back queue
//   in_valid/in_ready/in_reg/in_data : producer handshake offering a pending register write
//   hold, flush                       : write port busy this cycle / discard all pending writes
//   lookup1Sel/lookup2Sel -> hit*, fwdData* : decode-stage forwarding lookups
//   writeRegSel/writeEn/writeData     : register-file write port, count : occupancy
interface rf_wb_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_reg;
  logic [15:0]   in_data;
  logic          hold;
  logic          flush;
  logic [2:0]    lookup1Sel;
  logic [2:0]    lookup2Sel;
  logic          hit1;
  logic          hit2;
  logic [15:0]   fwdData1;
  logic [15:0]   fwdData2;
  logic [2:0]    writeRegSel;
  logic          writeEn;
  logic [15:0]   writeData;
  logic [CW-1:0] count;
  modport master (
    output in_valid, in_reg, in_data, hold, flush, lookup1Sel, lookup2Sel,
    input  in_ready, hit1, hit2, fwdData1, fwdData2, writeRegSel, writeEn, writeData, count
  );
  modport slave (
    input  in_valid, in_reg, in_data, hold, flush, lookup1Sel, lookup2Sel,
    output in_ready, hit1, hit2, fwdData1, fwdData2, writeRegSel, writeEn, writeData, count
  );
endinterface

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: in-order queue of pending register writes draining into the register file,
// with youngest-match forwarding for two decode lookups.
//   clk, rst : clock and asynchronous active-high reset
//   q        : rf_wb_queue_if slave (producer handshake, hold/flush, lookups, write port, count)
module rf_wb_queue #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  rf_wb_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    reg_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic          ready, we, push, any;
  always_comb begin
    // in_ready is gated by rst so it reads 0 while reset is held
    ready = !rst && (count_q < CW'(DEPTH));
    any = count_q != '0;
    we = any && !q.hold && !q.flush;
    push = q.in_valid && ready && !q.flush;
    head_d = q.flush ? '0 : head_q + PW'(we);
    tail_d = q.flush ? '0 : tail_q + PW'(push);
    count_d = q.flush ? '0 : count_q + CW'(push) - CW'(we);
    q.in_ready = ready;
    q.writeEn = we;
    q.writeRegSel = any ? reg_q[head_q] : 3'd0;
    q.writeData = any ? data_q[head_q] : 16'd0;
    q.count = count_q;
    q.hit1 = 1'b0;
    q.hit2 = 1'b0;
    q.fwdData1 = 16'd0;
    q.fwdData2 = 16'd0;
    idx = '0;
    // walk oldest to youngest so the last match seen is the youngest
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (reg_q[idx] == q.lookup1Sel) begin
          q.hit1 = 1'b1;
          q.fwdData1 = data_q[idx];
        end
        if (reg_q[idx] == q.lookup2Sel) begin
          q.hit2 = 1'b1;
          q.fwdData2 = data_q[idx];
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // entry storage is not reset; only occupied entries ever reach an output
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[tail_q] <= q.in_reg;
      data_q[tail_q] <= q.in_data;
    end
  end
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed vector table plus hand sequences for wrap, async reset and startup
module tb_rf_wb_queue;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rf_wb_queue_if #(.DEPTH(4)) bus();
  rf_wb_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .q(bus));
  typedef struct {
    logic iv; logic [2:0] ireg; logic [15:0] idat; logic hold; logic flush;
    logic [2:0] l1; logic [2:0] l2;
    logic rdy; logic [2:0] cnt; logic we; logic [2:0] sel; logic [15:0] wd;
    logic h1; logic [15:0] f1; logic h2; logic [15:0] f2;
  } vec_t;
  vec_t vq[$];
  logic [18:0] model_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic iv, input logic [2:0] r, input logic [15:0] d, input logic h, input logic f, input logic [2:0] l1, input logic [2:0] l2);
    bus.in_valid = iv; bus.in_reg = r; bus.in_data = d; bus.hold = h; bus.flush = f;
    bus.lookup1Sel = l1; bus.lookup2Sel = l2;
  endtask
  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(v.rdy));
    chk({tag, ".count"}, 32'(bus.count), 32'(v.cnt));
    chk({tag, ".writeEn"}, 32'(bus.writeEn), 32'(v.we));
    chk({tag, ".writeRegSel"}, 32'(bus.writeRegSel), 32'(v.sel));
    chk({tag, ".writeData"}, 32'(bus.writeData), 32'(v.wd));
    chk({tag, ".hit1"}, 32'(bus.hit1), 32'(v.h1));
    chk({tag, ".fwdData1"}, 32'(bus.fwdData1), 32'(v.f1));
    chk({tag, ".hit2"}, 32'(bus.hit2), 32'(v.h2));
    chk({tag, ".fwdData2"}, 32'(bus.fwdData2), 32'(v.f2));
  endtask
  initial begin
    vec_t z;
    z = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0};
    // iv reg data hold flush l1 l2 | rdy cnt we sel wd h1 f1 h2 f2
    vq.push_back('{0,0,16'h0000,0,0,0,0, 1,0,0,0,16'h0000,0,16'h0000,0,16'h0000});
    vq.push_back('{1,3,16'hBEEF,0,0,3,0, 1,0,0,0,16'h0000,0,16'h0000,0,16'h0000});
    vq.push_back('{0,0,16'h0000,0,0,3,0, 1,1,1,3,16'hBEEF,1,16'hBEEF,0,16'h0000});
    vq.push_back('{0,0,16'h0000,0,0,3,0, 1,0,0,0,16'h0000,0,16'h0000,0,16'h0000});
    vq.push_back('{1,1,16'h0001,1,0,0,0, 1,0,0,0,16'h0000,0,16'h0000,0,16'h0000});
    vq.push_back('{1,2,16'h0002,1,0,0,0, 1,1,0,1,16'h0001,0,16'h0000,0,16'h0000});
    vq.push_back('{1,3,16'h0003,1,0,0,0, 1,2,0,1,16'h0001,0,16'h0000,0,16'h0000});
    vq.push_back('{1,4,16'h0004,1,0,0,0, 1,3,0,1,16'h0001,0,16'h0000,0,16'h0000});
    vq.push_back('{1,5,16'h0005,1,0,4,5, 0,4,0,1,16'h0001,1,16'h0004,0,16'h0000});
    vq.push_back('{1,5,16'h0005,0,0,1,2, 0,4,1,1,16'h0001,1,16'h0001,1,16'h0002});
    vq.push_back('{0,0,16'h0000,0,0,1,2, 1,3,1,2,16'h0002,0,16'h0000,1,16'h0002});
    vq.push_back('{0,0,16'h0000,0,0,0,0, 1,2,1,3,16'h0003,0,16'h0000,0,16'h0000});
    vq.push_back('{0,0,16'h0000,0,0,0,0, 1,1,1,4,16'h0004,0,16'h0000,0,16'h0000});
    vq.push_back('{0,0,16'h0000,0,0,0,0, 1,0,0,0,16'h0000,0,16'h0000,0,16'h0000});
    vq.push_back('{1,5,16'h1111,1,0,5,6, 1,0,0,0,16'h0000,0,16'h0000,0,16'h0000});
    vq.push_back('{1,5,16'h2222,1,0,5,6, 1,1,0,5,16'h1111,1,16'h1111,0,16'h0000});
    vq.push_back('{0,0,16'h0000,1,0,5,6, 1,2,0,5,16'h1111,1,16'h2222,0,16'h0000});
    vq.push_back('{1,6,16'h3333,1,0,5,6, 1,2,0,5,16'h1111,1,16'h2222,0,16'h0000});
    vq.push_back('{0,0,16'h0000,1,0,6,5, 1,3,0,5,16'h1111,1,16'h3333,1,16'h2222});
    vq.push_back('{1,0,16'h0ABC,0,0,0,5, 1,3,1,5,16'h1111,0,16'h0000,1,16'h2222});
    vq.push_back('{0,0,16'h0000,1,0,0,5, 1,3,0,5,16'h2222,1,16'h0ABC,1,16'h2222});
    vq.push_back('{1,7,16'h7777,0,1,0,7, 1,3,0,5,16'h2222,1,16'h0ABC,0,16'h0000});
    vq.push_back('{0,0,16'h0000,0,0,0,7, 1,0,0,0,16'h0000,0,16'h0000,0,16'h0000});
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk_all("reset", z);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].iv, vq[i].ireg, vq[i].idat, vq[i].hold, vq[i].flush, vq[i].l1, vq[i].l2);
      #1 chk_all($sformatf("vec%0d", i), vq[i]);
      @(negedge clk);
    end
    for (int i = 0; i < 13; i++) begin
      drive(1, 3'(i), 16'h1000 + 16'(i), i < 3, 0, 0, 0);
      #1 chk("wrap.count", 32'(bus.count), 32'(model_q.size()));
      if (i >= 3) begin
        chk("wrap.writeEn", 32'(bus.writeEn), 32'd1);
        chk("wrap.head", {13'd0, bus.writeRegSel, bus.writeData}, {13'd0, model_q[0]});
        void'(model_q.pop_front());
      end
      model_q.push_back({3'(i), 16'h1000 + 16'(i)});
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    while (model_q.size() > 0) begin
      #1 chk("drain.count", 32'(bus.count), 32'(model_q.size()));
      chk("drain.head", {13'd0, bus.writeRegSel, bus.writeData}, {13'd0, model_q[0]});
      void'(model_q.pop_front());
      @(negedge clk);
    end
    #1 chk("drain.empty", 32'(bus.writeEn), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'(i + 1), 16'hA000 + 16'(i), 1, 0, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 1, 2);
    #1 chk("prerst.writeEn", 32'(bus.writeEn), 32'd1);
    chk("prerst.count", 32'(bus.count), 32'd3);
    #1 rst = 1'b1;
    #1 chk("arst.writeEn", 32'(bus.writeEn), 32'd0);
    chk("arst.count", 32'(bus.count), 32'd0);
    chk("arst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst.hit1", 32'(bus.hit1), 32'd0);
    @(negedge clk);
    #1 chk_all("arst_hold", z);
    rst = 1'b0;
    #1 chk("postrst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("postrst.writeEn", 32'(bus.writeEn), 32'd0);
    @(negedge clk);
    #1 chk("postrst.count", 32'(bus.count), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write entries; legal values 2, 4, 8.
REQ-002 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, reset; asynchronous, active-high.
REQ-004 Port in_valid, input, 1, producer offers a register write.
REQ-005 Port in_ready, output, 1, queue can accept an entry this cycle.
REQ-006 Port in_reg, input, 3, destination register of the offered write.
REQ-007 Port in_data, input, 16, data of the offered write.
REQ-008 Port hold, input, 1, write port unavailable this cycle; no drain.
REQ-009 Port flush, input, 1, discard all pending entries.
REQ-010 Port lookup1Sel and lookup2Sel, input, 3 each, registers being read by decode.
REQ-011 Port hit1 and hit2, output, 1 each, a pending entry targets the corresponding lookup register.
REQ-012 Port fwdData1 and fwdData2, output, 16 each, youngest pending data for the corresponding lookup register.
REQ-013 Port writeRegSel, writeEn and writeData, outputs of 3, 1 and 16 bits, drive the register-file write port.
REQ-014 Port count, output, log2(DEPTH)+1 bits, number of occupied entries.

Function
REQ-015 The block SHALL be an in-order FIFO of {reg[2:0], data[15:0]} entries with head/tail pointers wrapping modulo DEPTH.
REQ-016 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on hold or on a same-cycle pop.
REQ-017 A push SHALL occur when in_valid and in_ready are both high and flush is low; in_reg and in_data are captured at the tail.
REQ-018 writeEn SHALL equal (count > 0) and not hold and not flush, decoded from registered state only.
REQ-019 writeRegSel and writeData SHALL show the head entry when count > 0, and 0 when count = 0.
REQ-020 A pop SHALL occur on every edge at which writeEn is high.
REQ-021 Latency: an entry pushed into an empty queue at edge N SHALL appear on the write port in cycle N+1 (no same-cycle passthrough).
REQ-022 On a simultaneous push and pop, count SHALL stay unchanged, and a full queue SHALL remain full.
REQ-023 in_valid with in_ready low SHALL cause no state change; the producer holds the request.
REQ-024 A flush SHALL clear count and both pointers at the next edge, and SHALL take priority over push and pop in that cycle.
REQ-025 hitK SHALL be 1 iff any occupied entry, including the head, has reg equal to lookupKSel.
REQ-026 fwdDataK SHALL equal the data of the youngest matching entry (closest to the tail), or 0 when hitK is 0.
REQ-027 Lookups SHALL be purely combinational on current state and SHALL ignore same-cycle in_* values.
REQ-028 Lookup outputs SHALL treat register 0 like any other register, with no special zero-register handling.

Reset
REQ-029 While rst is high, count, the pointers, writeEn, writeRegSel, writeData, hit1, hit2, fwdData1, fwdData2 and in_ready SHALL all be 0.
REQ-030 An rst assertion mid-drain SHALL drop all entries immediately, with no further writeEn pulses.
REQ-031 After rst falls, in_ready SHALL be 1 in the first cycle.
REQ-032 Entry storage contents need not be reset, provided no unoccupied entry is ever observable on any output.

Verification
REQ-033 Single write: push (reg 3, 0xBEEF) into an empty queue with hold=0 -> the next cycle shows writeEn=1, writeRegSel=3, writeData=0xBEEF, and count returns to 0 after it.
REQ-034 Fill and order: hold=1, push (1,0x0001) through (4,0x0004) -> count=4 and in_ready=0; a 5th offer is not accepted; release hold -> writes 1, 2, 3, 4 appear on consecutive cycles.
REQ-035 Youngest forward: hold=1, push (5,0x1111) then (5,0x2222), lookup1Sel=5 -> hit1=1 and fwdData1=0x2222; lookup2Sel=6 -> hit2=0 and fwdData2=0.
REQ-036 Full with simultaneous push/pop: count=4 and hold=0 -> in_ready=0 and the push is not taken; at count=3, push and pop together -> count stays 3; pointer wrap is verified over 10 or more entries.
REQ-037 Flush versus push: count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, writeEn=0, and the offered entry is dropped.
REQ-038 Asynchronous reset: count=3, assert rst between clock edges -> writeEn=0 and count=0 immediately, before the next edge.
